// File: rtl/rot_word_serializer.sv
// Serializer: buffers one rotated word behind a valid/ready handshake and shifts it out LSB-first.
// Optional even-parity trailer bit is enabled by defining ROT_SER_PARITY_EN.
module rot_word_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned GapW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

`ifdef ROT_SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StGap, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
`ifdef ROT_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic load_now;
  logic accept;
  logic frame_done;

  always_comb begin
    load_now = (state_q == StIdle) && buf_full_q;
    in_ready = rst_n && (!buf_full_q || load_now);
    accept   = in_valid && in_ready;

    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;
`ifdef ROT_SER_PARITY_EN
    par_d       = par_q;
`endif

    // A load and a fresh accept on the same edge leave the buffer full with the new word.
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end else if (load_now) begin
      buf_full_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          sreg_d    = buf_q;
          bit_cnt_d = '0;
`ifdef ROT_SER_PARITY_EN
          par_d     = ^buf_q;
`endif
          state_d   = StShift;
        end
      end
      StShift: begin
        sreg_d    = sreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == BitLast) begin
`ifdef ROT_SER_PARITY_EN
          state_d = StPar;
`else
          frame_done = 1'b1;
`endif
        end
      end
`ifdef ROT_SER_PARITY_EN
      StPar: frame_done = 1'b1;
`endif
      StGap: begin
        gap_cnt_d = gap_cnt_q + GapW'(1);
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      gap_cnt_d   = '0;
      state_d     = (FRAME_GAP > 0) ? StGap : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
`ifdef ROT_SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef ROT_SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Serial outputs decode only registered state, never the upstream inputs.
  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      StShift: begin
        ser_valid = 1'b1;
        ser_out   = sreg_q[0];
`ifndef ROT_SER_PARITY_EN
        ser_last  = (bit_cnt_q == BitLast);
`endif
      end
`ifdef ROT_SER_PARITY_EN
      StPar: begin
        ser_valid = 1'b1;
        ser_out   = par_q;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle) || buf_full_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rot_word_serializer.sv
// Directed bench for rot_word_serializer (WIDTH=4, FRAME_GAP=1); parity cases follow ROT_SER_PARITY_EN.
module tb_rot_word_serializer;

  localparam int unsigned FrameGap = 1;
`ifdef ROT_SER_PARITY_EN
  localparam int unsigned FLen = 5;
`else
  localparam int unsigned FLen = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rot_word_serializer #(
    .WIDTH    (4),
    .FRAME_GAP(FrameGap)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      obs = {in_ready, ser_out, ser_valid, ser_last, busy, frame_cnt};
      n_checks++;
      if (obs !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected all zero", c, obs);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_bits;
    exp_bits = 5'b11011;  // 1011 LSB-first, then parity 1
    in_valid = 1'b1;
    in_data  = 4'b1011;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < int'(FLen); i++) begin
      n_checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[i] || ser_last !== (i == int'(FLen) - 1)) begin
        n_fail++;
        $display("FAIL single_bit%0d: valid=%b out=%b last=%b expected 1 %b %b",
                 i, ser_valid, ser_out, ser_last, exp_bits[i], (i == int'(FLen) - 1));
      end
      tick();
    end
    n_checks++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_gap: valid=%b out=%b frame_cnt=%0d expected 0 0 1",
               ser_valid, ser_out, frame_cnt);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b valid=%b expected 0 0", busy, ser_valid);
    end
  endtask

`ifdef ROT_SER_PARITY_EN
  task automatic test_parity();
    logic [4:0] exp_bits;
    exp_bits = 5'b00011;  // 0011 LSB-first, parity 0
    in_valid = 1'b1;
    in_data  = 4'b0011;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[i] || ser_last !== (i == 4)) begin
        n_fail++;
        $display("FAIL parity_bit%0d: valid=%b out=%b last=%b expected 1 %b %b",
                 i, ser_valid, ser_out, ser_last, exp_bits[i], (i == 4));
      end
      tick();
    end
    n_checks++;
    if (frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL parity_frame_cnt: got %0d expected 2", frame_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back(input logic [7:0] fc_before);
    logic [3:0]  words [3];
    logic [14:0] got;
    logic [14:0] exp_stream;
    int          idx;
    int          nacc;
    int          nbits;
    int          gap_run;
    bit          in_gap;
    bit          acc;
    words = '{4'hA, 4'h5, 4'hF};
`ifdef ROT_SER_PARITY_EN
    exp_stream = {1'b0, 4'hF, 1'b0, 4'h5, 1'b0, 4'hA};
`else
    exp_stream = {3'b000, 4'hF, 4'h5, 4'hA};
`endif
    got      = '0;
    idx      = 0;
    nacc     = 0;
    nbits    = 0;
    gap_run  = 0;
    in_gap   = 1'b0;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ser_valid) begin
        if (in_gap) begin
          n_checks++;
          if (gap_run != int'(FrameGap) + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d idle cycles expected %0d", gap_run, FrameGap + 1);
          end
        end
        in_gap  = ser_last;
        gap_run = 0;
        if (nbits < 15) got[nbits] = ser_out;
        nbits++;
      end else begin
        gap_run++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 2) begin
          n_checks++;
          if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_drop: in_ready=%b expected 0", in_ready);
          end
        end
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else in_data = words[idx];
      end
    end
    n_checks++;
    if (nbits != 3 * int'(FLen) || got !== exp_stream) begin
      n_fail++;
      $display("FAIL b2b_stream: got %0d bits %b expected %0d bits %b",
               nbits, got, 3 * FLen, exp_stream);
    end
    n_checks++;
    if (frame_cnt !== fc_before + 8'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: frame_cnt=%0d busy=%b expected %0d 0",
               frame_cnt, busy, fc_before + 8'd3);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    in_valid = 1'b1;
    in_data  = 4'h6;
    tick();
    in_data = 4'h9;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bit0: valid=%b out=%b expected 1 0", ser_valid, ser_out);
    end
    tick();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_bit1: valid=%b out=%b busy=%b expected 1 1 1",
               ser_valid, ser_out, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (ser_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen || frame_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: saw_valid=%b frame_cnt=%0d busy=%b expected 0 0 0",
               seen, frame_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    int  nacc;
    int  nlast;
    bit  acc;
    bit  idle;
    nacc     = 0;
    nlast    = 0;
    idle     = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h3;
    for (int cyc = 0; cyc < 256 * (int'(FLen) + int'(FrameGap) + 1) + 100; cyc++) begin
      if (ser_last === 1'b1) nlast++;
      if (!in_valid && !busy) begin
        idle = 1'b1;
        break;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 256) in_valid = 1'b0;
      end
    end
    n_checks++;
    if (!idle || nlast != 256 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_256: idle=%b frames=%0d frame_cnt=%0d expected 1 256 0",
               idle, nlast, frame_cnt);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    idle     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!idle || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap_257: idle=%b frame_cnt=%0d expected 1 1", idle, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef ROT_SER_PARITY_EN
    test_parity();
    test_back_to_back(8'd2);
`else
    test_back_to_back(8'd1);
`endif
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
